// File: rtl/pico_mem_bridge.sv
// Shared word RAM bridging Caravel Wishbone and picorv32 native memory bus.
// Optional STALLCNT counter enabled by defining PICO_MEM_STALLCNT_EN.
module pico_mem_bridge #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] WB_BASE    = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        core_trap,
  output logic        core_resetn,
  output logic        irq_o
);

  localparam int AW = ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_cpu_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          run_q, run_d;
  logic          trap_q, trap_d;
  logic          oob_q, oob_d;
  logic          resetn_q;
  logic          trap_prev_q;
  logic          irq_q;
  logic [31:0]   stall_rd;
  logic [31:0]   mem_q [0:(1<<AW)-1];

  logic          wb_hit, wb_ctl, cpu_oob, idle;
  logic          gnt_wb, gnt_cpu;
  logic [AW-1:0] wb_idx, cpu_idx, ram_idx;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wd, ram_rd, ctl_rd;
  logic          ctl_wr, ctrl_wr, trap_edge;
  logic          unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], mem_addr[1:0]};

  assign wb_hit  = wbs_cyc_i & wbs_stb_i &
                   (wbs_adr_i[31:AW+3] == WB_BASE[31:AW+3]);
  assign wb_ctl  = wbs_adr_i[AW+2];
  assign wb_idx  = wbs_adr_i[AW+1:2];
  assign cpu_idx = mem_addr[AW+1:2];
  assign cpu_oob = |mem_addr[31:AW+2];
  assign idle    = (state_q == S_IDLE);

  // On a tie the master not served last wins.
  assign gnt_wb  = idle & wb_hit & (~mem_valid | last_cpu_q);
  assign gnt_cpu = idle & mem_valid & ~gnt_wb;

  always_comb begin
    ram_idx = cpu_idx;
    ram_be  = 4'b0;
    ram_wd  = mem_wdata;
    if (gnt_wb) begin
      ram_idx = wb_idx;
      ram_wd  = wbs_dat_i;
      ram_be  = (wbs_we_i & ~wb_ctl) ? wbs_sel_i : 4'b0;
    end else if (gnt_cpu) begin
      ram_be  = cpu_oob ? 4'b0 : mem_wstrb;
    end
  end

  assign ram_rd = mem_q[ram_idx];

  always_ff @(posedge wb_clk_i) begin
    for (int i = 0; i < 4; i++)
      if (ram_be[i]) mem_q[ram_idx][8*i +: 8] <= ram_wd[8*i +: 8];
  end

  always_comb begin
    ctl_rd = 32'b0;
    if (wb_idx == AW'(0))      ctl_rd = {29'b0, oob_q, trap_q, run_q};
    else if (wb_idx == AW'(1)) ctl_rd = stall_rd;
  end

  assign ctl_wr    = gnt_wb & wb_ctl & wbs_we_i;
  assign ctrl_wr   = ctl_wr & (wb_idx == AW'(0)) & wbs_sel_i[0];
  assign trap_edge = core_trap & ~trap_prev_q;

  always_comb begin
    rdata_d = rdata_q;
    if (gnt_wb)       rdata_d = wb_ctl ? ctl_rd : ram_rd;
    else if (gnt_cpu) rdata_d = cpu_oob ? 32'b0 : ram_rd;
    run_d  = ctrl_wr ? wbs_dat_i[0] : run_q;
    trap_d = trap_edge | (trap_q & ~(ctrl_wr & wbs_dat_i[1]));
    oob_d  = (gnt_cpu & cpu_oob) | (oob_q & ~(ctrl_wr & wbs_dat_i[2]));
    state_d = S_IDLE;
    if (gnt_wb)       state_d = S_WB;
    else if (gnt_cpu) state_d = S_CPU;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      last_cpu_q  <= 1'b1;
      rdata_q     <= 32'b0;
      run_q       <= 1'b0;
      trap_q      <= 1'b0;
      oob_q       <= 1'b0;
      resetn_q    <= 1'b0;
      trap_prev_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      run_q       <= run_d;
      trap_q      <= trap_d;
      oob_q       <= oob_d;
      resetn_q    <= run_q;
      trap_prev_q <= core_trap;
      irq_q       <= trap_edge;
      if (state_q == S_WB)  last_cpu_q <= 1'b0;
      if (state_q == S_CPU) last_cpu_q <= 1'b1;
    end
  end

`ifdef PICO_MEM_STALLCNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts CPU cycles blocked by a WB grant or WB service; clear wins.
  always_comb begin
    stall_d = stall_q;
    if (mem_valid & (gnt_wb | (state_q == S_WB)) & ~&stall_q)
      stall_d = stall_q + 32'd1;
    if (ctl_wr & (wb_idx == AW'(1)))
      stall_d = 32'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) stall_q <= 32'b0;
    else          stall_q <= stall_d;
  end

  assign stall_rd = stall_q;
`else
  assign stall_rd = 32'b0;
`endif

  assign wbs_ack_o   = (state_q == S_WB);
  assign wbs_dat_o   = wbs_ack_o ? rdata_q : 32'b0;
  assign mem_ready   = (state_q == S_CPU);
  assign mem_rdata   = mem_ready ? rdata_q : 32'b0;
  assign core_resetn = resetn_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_pico_mem_bridge.sv
// Directed self-checking bench for pico_mem_bridge (default ADDR_WIDTH=10).
module tb_pico_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        mvalid = 1'b0;
  logic [31:0] maddr = 32'h0, mwdata = 32'h0;
  logic [3:0]  mwstrb = 4'h0;
  logic        mready;
  logic [31:0] mrdata;
  logic        trap = 1'b0;
  logic        resetn, irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] stall_exp;

  localparam logic [31:0] RAM0  = 32'h3000_0000;
  localparam logic [31:0] CTRL  = 32'h3000_1000;
  localparam logic [31:0] STALL = 32'h3000_1004;

  pico_mem_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .mem_valid(mvalid), .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_wstrb(mwstrb), .mem_ready(mready), .mem_rdata(mrdata),
    .core_trap(trap), .core_resetn(resetn), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d,
                         input string tag, input logic chkd,
                         input logic [31:0] exp);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    tick;
    chk({tag, ".ack"}, {31'b0, ack}, 32'd1);
    if (chkd) chk({tag, ".dat"}, rdat, exp);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick;
  endtask

  task automatic cpu_xfer(input logic [31:0] a, input logic [3:0] st,
                          input logic [31:0] d, input string tag,
                          input logic [31:0] exp);
    mvalid = 1'b1; maddr = a; mwstrb = st; mwdata = d;
    tick;
    chk({tag, ".rdy"}, {31'b0, mready}, 32'd1);
    chk({tag, ".dat"}, mrdata, exp);
    mvalid = 1'b0;
    tick;
  endtask

  initial begin
`ifdef PICO_MEM_STALLCNT_EN
    stall_exp = 32'd2;
`else
    stall_exp = 32'd0;
`endif
    tick;
    tick;
    chk("rst.ack", {31'b0, ack}, 32'd0);
    chk("rst.rdy", {31'b0, mready}, 32'd0);
    chk("rst.dat", rdat | mrdata, 32'd0);
    chk("rst.resetn", {31'b0, resetn}, 32'd0);
    rst = 1'b0;
    tick;

    wb_xfer(RAM0, 1'b1, 4'hF, 32'hDEADBEEF, "wr0", 1'b0, 32'h0);
    wb_xfer(RAM0, 1'b0, 4'hF, 32'h0, "rd0", 1'b1, 32'hDEADBEEF);
    chk("idle.dat", rdat, 32'd0);
    chk("resetn.low", {31'b0, resetn}, 32'd0);

    wb_xfer(RAM0, 1'b1, 4'b0010, 32'h0000_AB00, "wrb", 1'b0, 32'h0);
    wb_xfer(RAM0, 1'b0, 4'hF, 32'h0, "rdb", 1'b1, 32'hDEADABEF);

    cyc = 1'b1; stb = 1'b1; adr = 32'h2000_0000;
    tick;
    chk("unsel.ack", {31'b0, ack}, 32'd0);
    tick;
    chk("unsel.ack2", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick;

    wb_xfer(CTRL, 1'b1, 4'hF, 32'h1, "run", 1'b0, 32'h0);
    chk("resetn.high", {31'b0, resetn}, 32'd1);

    cpu_xfer(32'h0, 4'h0, 32'h0, "cpurd", 32'hDEADABEF);

    // Collision with WB winning the first tie.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = RAM0;
    mvalid = 1'b1; maddr = 32'h0; mwstrb = 4'h0;
    tick;
    chk("col1.ack", {31'b0, ack}, 32'd1);
    chk("col1.wdat", rdat, 32'hDEADABEF);
    chk("col1.rdy0", {31'b0, mready}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick;
    chk("col1.rdy1", {31'b0, mready}, 32'd0);
    tick;
    chk("col1.rdy", {31'b0, mready}, 32'd1);
    chk("col1.cdat", mrdata, 32'hDEADABEF);
    mvalid = 1'b0;
    tick;

    wb_xfer(STALL, 1'b0, 4'hF, 32'h0, "stall1", 1'b1, stall_exp);

    // Last grant was WB, so the next tie goes to the CPU.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = RAM0;
    mvalid = 1'b1; maddr = 32'h0; mwstrb = 4'h0;
    tick;
    chk("col2.rdy", {31'b0, mready}, 32'd1);
    chk("col2.ack0", {31'b0, ack}, 32'd0);
    mvalid = 1'b0;
    tick;
    chk("col2.ack1", {31'b0, ack}, 32'd0);
    tick;
    chk("col2.ack", {31'b0, ack}, 32'd1);
    chk("col2.wdat", rdat, 32'hDEADABEF);
    cyc = 1'b0; stb = 1'b0;
    tick;

    wb_xfer(CTRL, 1'b1, 4'hF, 32'h0, "stop", 1'b0, 32'h0);
    chk("resetn.off", {31'b0, resetn}, 32'd0);

    cpu_xfer(32'h0000_1000, 4'hF, 32'h1234_5678, "oob", 32'h0);
    wb_xfer(RAM0, 1'b0, 4'hF, 32'h0, "oob.ram", 1'b1, 32'hDEADABEF);
    wb_xfer(CTRL, 1'b0, 4'hF, 32'h0, "oob.ctrl", 1'b1, 32'h4);
    wb_xfer(CTRL, 1'b1, 4'hF, 32'h4, "oob.w1c", 1'b0, 32'h0);
    wb_xfer(CTRL, 1'b0, 4'hF, 32'h0, "oob.clr", 1'b1, 32'h0);

    chk("irq.pre", {31'b0, irq}, 32'd0);
    trap = 1'b1;
    tick;
    chk("irq.pulse", {31'b0, irq}, 32'd1);
    tick;
    chk("irq.end", {31'b0, irq}, 32'd0);
    wb_xfer(CTRL, 1'b0, 4'hF, 32'h0, "trap.ctrl", 1'b1, 32'h2);
    chk("irq.once", {31'b0, irq}, 32'd0);
    wb_xfer(CTRL, 1'b1, 4'hF, 32'h2, "trap.w1c", 1'b0, 32'h0);
    wb_xfer(CTRL, 1'b0, 4'hF, 32'h0, "trap.clr", 1'b1, 32'h0);

    wb_xfer(STALL, 1'b0, 4'hF, 32'h0, "stall2", 1'b1, stall_exp);
    wb_xfer(STALL, 1'b1, 4'hF, 32'h0, "stall.wr", 1'b0, 32'h0);
    wb_xfer(STALL, 1'b0, 4'hF, 32'h0, "stall.clr", 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
